// File: rtl/sv_bus_pkg.sv
// Shared bus definitions for the sv_bus_fifo family.
// The default data width follows the global BUS_WIDTH define, or 8 when it is absent.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

package sv_bus_pkg;

    localparam int DEFAULT_BUS_WIDTH = `BUS_WIDTH;

    typedef logic [DEFAULT_BUS_WIDTH-1:0] bus_word_t;

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Even-parity bit over an arbitrary-width word; reduction XOR of {word, bit} is 0.
    function automatic logic even_parity(input logic [1023:0] word, input int width);
        logic p;
        p = 1'b0;
        for (int i = 0; i < width; i++) begin
            p = p ^ word[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/sv_bus_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module sv_bus_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the write word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sv_bus_fifo.sv
// Synchronous valid/ready FIFO with occupancy level, almost-full flag and flush.
// Optional feature macro: SV_BUS_FIFO_PARITY_EN adds a stored even-parity bit per
// entry and the parity_err output on the head entry.
module sv_bus_fifo
    import sv_bus_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [LW-1:0]        level,
`ifdef SV_BUS_FIFO_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 almost_full
);

    localparam int AW = $clog2(DEPTH);
`ifdef SV_BUS_FIFO_PARITY_EN
    localparam int MW = BUS_WIDTH + 1;
`else
    localparam int MW = BUS_WIDTH;
`endif
    localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);
    localparam logic [LW-1:0] AF_COUNT   = LW'(AF_THRESH);

    // Reject illegal configurations at elaboration.
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sv_bus_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("sv_bus_fifo: AF_THRESH must lie in 1..DEPTH");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("sv_bus_fifo: BUS_WIDTH must be at least 1");
    end

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          push_s;
    logic          pop_s;
    logic [MW-1:0] wdata_s;
    logic [MW-1:0] rdata_s;

    assign in_ready    = !rst && (count_r != FULL_COUNT);
    assign out_valid   = (count_r != {LW{1'b0}});
    assign push_s      = in_valid && in_ready;
    assign pop_s       = out_valid && out_ready;
    assign level       = count_r;
    assign almost_full = (count_r >= AF_COUNT);
    assign out_data    = rdata_s[BUS_WIDTH-1:0];

`ifdef SV_BUS_FIFO_PARITY_EN
    assign wdata_s    = {even_parity(1024'(in_data), BUS_WIDTH), in_data};
    assign parity_err = out_valid && (^rdata_s);
`else
    assign wdata_s    = in_data;
`endif

    // Pointer and occupancy bookkeeping; flush discards any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    sv_bus_fifo_mem #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s && !flush),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_sv_bus_fifo.sv
// Self-checking bench for sv_bus_fifo (BUS_WIDTH=8, DEPTH=4, AF_THRESH=3).
// A queue models FIFO contents; it is updated from the handshakes the bench itself predicts.
module tb_sv_bus_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       almost_full;
`ifdef SV_BUS_FIFO_PARITY_EN
    logic       parity_err;
`endif

    int errors;
    int checks;
    logic [7:0] sb[$];

    sv_bus_fifo #(
        .BUS_WIDTH (8),
        .DEPTH     (4),
        .AF_THRESH (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
`ifdef SV_BUS_FIFO_PARITY_EN
        .parity_err  (parity_err),
`endif
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, updating the model from the predicted handshakes.
    task automatic tick();
        logic       acc;
        logic       rel;
        logic [7:0] d;
        acc = in_valid && !rst && (sb.size() != 4);
        rel = out_ready && (sb.size() != 0);
        d   = in_data;
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (rel) void'(sb.pop_front());
            if (acc) sb.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        sb.delete();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_cycle0_valid got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_cycle1_valid got %b want 1", out_valid); end
        checks++; if (out_data !== sb[0] || sb[0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, in_ready); end
            checks++; if (almost_full !== (sb.size() >= 3)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, sb.size() >= 3); end
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af got %b want 1", almost_full); end
        in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fifth_refused_level got %0d want 4", level); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== sb[0] || out_data !== 8'(i)) begin
                errors++; $display("FAIL drain[%0d] got %h want %h", i, out_data, 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] next_d;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
        end
        next_d = 8'h14;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic acc;
            in_valid = 1'b1; in_data = next_d;
            acc = (sb.size() != 4);
            checks++; if (in_ready !== acc) begin errors++; $display("FAIL stream_in_ready[%0d] got %b want %b", k, in_ready, acc); end
            checks++; if (out_data !== sb[0] || out_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", k, out_data, 8'h10 + 8'(k)); end
            if (k > 0) begin
                checks++; if (level !== 3'd3) begin errors++; $display("FAIL stream_level[%0d] got %0d want 3", k, level); end
            end
            tick();
            if (acc) next_d = next_d + 8'h01;
        end
        in_valid = 1'b0;
        while (sb.size() != 0) begin
            checks++; if (out_data !== sb[0]) begin errors++; $display("FAIL stream_tail got %h want %h", out_data, sb[0]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h20 + 8'(i);
            tick();
        end
        in_data = 8'h55; flush = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_data !== sb[0] || out_data !== 8'h66) begin errors++; $display("FAIL post_flush_data got %h want 66", out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'h70 + 8'(i);
            tick();
        end
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready got %b want 0", in_ready); end
        sb.delete();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL arst_recover_data got %h want 3c", out_data); end
        tick();
        out_ready = 1'b0;
    endtask

`ifdef SV_BUS_FIFO_PARITY_EN
    task automatic test_parity();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        in_valid = 1'b1; in_data = 8'h07;
        tick();
        in_valid = 1'b0;
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean07 got %b want 0", parity_err); end
        u_dut.u_mem.mem_r[0][8] = ~u_dut.u_mem.mem_r[0][8];
        #1;
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_forced got %b want 1", parity_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h03;
        tick();
        in_valid = 1'b0;
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean03 got %b want 0", parity_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    // Run every scenario in order and report.
    initial begin
        errors = 0;
        checks = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef SV_BUS_FIFO_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
